// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: memory-mapped GPIO controller for the pad ring.
// Sync + glitch filter + edge interrupts on the input path.
//
// Ports:
//   clk, rst      core clock, async active-high reset
//   we_i          single-cycle bus write strobe
//   addr_i        byte address, [4:2] selects the register
//   data_i/data_o write data / combinational read data
//   gpio_io_ctrl  2 bits per pin (00/11 hi-Z, 01 out, 10 in)
//   gpio_out      pad output data
//   gpio_in       raw asynchronous pad input data
//   irq_o         registered OR of pending interrupt status
module gpio_pad_ctrl #(
    parameter int          GPIO_NUM = 16,
    parameter logic [15:0] DIV_RST  = 16'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           data_i,
    output logic [31:0]           data_o,
    output logic [2*GPIO_NUM-1:0] gpio_io_ctrl,
    output logic [GPIO_NUM-1:0]   gpio_out,
    input  logic [GPIO_NUM-1:0]   gpio_in,
    output logic                  irq_o
);

    logic [2*GPIO_NUM-1:0] r_ctrl;
    logic [GPIO_NUM-1:0]   r_out;
    logic [GPIO_NUM-1:0]   r_en_rise;
    logic [GPIO_NUM-1:0]   r_en_fall;
    logic [GPIO_NUM-1:0]   r_stat;
    logic [15:0]           r_div;
    logic [15:0]           r_cnt;
    logic [GPIO_NUM-1:0]   r_sync1;
    logic [GPIO_NUM-1:0]   r_sync2;
    logic [2:0]            r_hist [GPIO_NUM];
    logic [GPIO_NUM-1:0]   r_filt;
    logic [GPIO_NUM-1:0]   r_filt_q;
    logic                  r_irq;

    logic [2:0]          w_sel;
    logic                w_wr_ctrl;
    logic                w_wr_data;
    logic                w_wr_en;
    logic                w_wr_stat;
    logic                w_wr_div;
    logic                w_tick;
    logic [GPIO_NUM-1:0] w_in_mode;
    logic [GPIO_NUM-1:0] w_din;
    logic [GPIO_NUM-1:0] w_ev;
    logic [GPIO_NUM-1:0] w_clr;
    logic [2:0]          w_hnew [GPIO_NUM];
    logic [31:0]         w_en_rd;
    logic                w_unused;

    assign w_sel     = addr_i[4:2];
    assign w_wr_ctrl = we_i && (w_sel == 3'd0);
    assign w_wr_data = we_i && (w_sel == 3'd1);
    assign w_wr_en   = we_i && (w_sel == 3'd2);
    assign w_wr_stat = we_i && (w_sel == 3'd3);
    assign w_wr_div  = we_i && (w_sel == 3'd4);
    assign w_tick    = (r_cnt == r_div);
    assign w_clr     = w_wr_stat ? data_i[GPIO_NUM-1:0] : '0;
    assign w_unused  = ^{addr_i[31:5], addr_i[1:0]};

    always_comb begin
        w_en_rd = '0;
        w_en_rd[GPIO_NUM-1:0]  = r_en_rise;
        w_en_rd[16 +: GPIO_NUM] = r_en_fall;
        for (int i = 0; i < GPIO_NUM; i++) begin
            w_in_mode[i] = (r_ctrl[2*i +: 2] == 2'b10);
            w_din[i]     = w_in_mode[i] ? r_filt[i] : r_out[i];
            w_hnew[i]    = {r_hist[i][1:0], r_sync2[i]};
        end
    end

    // filt_q lags filt by one cycle, so an edge is seen the
    // cycle after filt moves and lands in INT_STAT one later.
    assign w_ev = ((r_filt & ~r_filt_q & r_en_rise) |
                   (~r_filt & r_filt_q & r_en_fall)) & w_in_mode;

    always_comb begin
        data_o = '0;
        case (w_sel)
            3'd0:    data_o = 32'(r_ctrl);
            3'd1:    data_o = 32'(w_din);
            3'd2:    data_o = w_en_rd;
            3'd3:    data_o = 32'(r_stat);
            3'd4:    data_o = 32'(r_div);
            default: data_o = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl    <= '0;
            r_out     <= '0;
            r_en_rise <= '0;
            r_en_fall <= '0;
            r_div     <= DIV_RST;
        end else begin
            if (w_wr_ctrl) r_ctrl <= data_i[2*GPIO_NUM-1:0];
            if (w_wr_data) r_out  <= data_i[GPIO_NUM-1:0];
            if (w_wr_en) begin
                r_en_rise <= data_i[GPIO_NUM-1:0];
                r_en_fall <= data_i[16 +: GPIO_NUM];
            end
            if (w_wr_div) r_div <= data_i[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_stat  <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (w_wr_div || w_tick) r_cnt <= '0;
            else                    r_cnt <= r_cnt + 16'd1;
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
            // a new event beats a simultaneous write-1-to-clear
            r_stat  <= (r_stat & ~w_clr) | w_ev;
            r_irq   <= |r_stat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt   <= '0;
            r_filt_q <= '0;
            for (int i = 0; i < GPIO_NUM; i++) r_hist[i] <= '0;
        end else begin
            r_filt_q <= r_filt;
            for (int i = 0; i < GPIO_NUM; i++) begin
                if (!w_in_mode[i]) begin
                    r_hist[i] <= '0;
                    r_filt[i] <= 1'b0;
                end else if (w_tick) begin
                    r_hist[i] <= w_hnew[i];
                    if (w_hnew[i] == 3'b111)      r_filt[i] <= 1'b1;
                    else if (w_hnew[i] == 3'b000) r_filt[i] <= 1'b0;
                end
            end
        end
    end

    assign gpio_io_ctrl = r_ctrl;
    assign gpio_out     = r_out;
    assign irq_o        = r_irq;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb_gpio_pad_ctrl: directed + random stimulus against a
// run-length reference model of the GPIO controller.
module tb_gpio_pad_ctrl;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic [31:0] gpio_io_ctrl;
    logic [15:0] gpio_out;
    logic [15:0] gpio_in;
    logic        irq_o;

    gpio_pad_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .gpio_io_ctrl(gpio_io_ctrl),
        .gpio_out    (gpio_out),
        .gpio_in     (gpio_in),
        .irq_o       (irq_o)
    );

    localparam logic [31:0] A_CTRL = 32'h0;
    localparam logic [31:0] A_DATA = 32'h4;
    localparam logic [31:0] A_EN   = 32'h8;
    localparam logic [31:0] A_STAT = 32'hC;
    localparam logic [31:0] A_DIV  = 32'h10;

    int errors;
    int checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] m_ctrl, m_en;
    logic [15:0] m_out, m_stat, m_div;
    logic [15:0] m_s1, m_s2, m_filt, m_fprev;
    logic        m_irq;
    int          m_phase;
    bit          m_last [16];
    int          m_run  [16];

    task automatic model_reset();
        m_ctrl = '0; m_en = '0; m_out = '0; m_stat = '0;
        m_div = '0; m_s1 = '0; m_s2 = '0; m_filt = '0;
        m_fprev = '0; m_irq = 1'b0; m_phase = 0;
        for (int n = 0; n < 16; n++) begin
            m_last[n] = 1'b0;
            m_run[n]  = 3;
        end
    endtask

    function automatic logic [15:0] m_inmode();
        logic [15:0] r;
        for (int n = 0; n < 16; n++)
            r[n] = (m_ctrl[2*n +: 2] == 2'b10);
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [15:0] im;
        logic [31:0] r;
        im = m_inmode();
        r = '0;
        case (a[4:2])
            3'd0: r = m_ctrl;
            3'd1: for (int n = 0; n < 16; n++)
                      r[n] = im[n] ? m_filt[n] : m_out[n];
            3'd2: r = m_en;
            3'd3: r = {16'h0, m_stat};
            3'd4: r = {16'h0, m_div};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Advance the model across one clock edge using current inputs.
    task automatic model_edge();
        logic [15:0] im, ev, nf, clr;
        logic        tick;
        int          sel;
        im   = m_inmode();
        ev   = ((m_filt & ~m_fprev & m_en[15:0]) |
                (~m_filt & m_fprev & m_en[31:16])) & im;
        tick = (m_phase == int'(m_div));
        sel  = int'(addr_i[4:2]);
        nf   = m_filt;
        for (int n = 0; n < 16; n++) begin
            if (!im[n]) begin
                m_last[n] = 1'b0;
                m_run[n]  = 3;
                nf[n]     = 1'b0;
            end else if (tick) begin
                if (m_s2[n] == m_last[n]) begin
                    if (m_run[n] < 3) m_run[n]++;
                end else begin
                    m_last[n] = m_s2[n];
                    m_run[n]  = 1;
                end
                if (m_run[n] >= 3) nf[n] = m_last[n];
            end
        end
        clr     = (we_i && sel == 3) ? data_i[15:0] : 16'h0;
        m_irq   = |m_stat;
        m_stat  = (m_stat & ~clr) | ev;
        m_fprev = m_filt;
        m_filt  = nf;
        m_phase = ((we_i && sel == 4) || tick) ? 0 : m_phase + 1;
        m_s2    = m_s1;
        m_s1    = gpio_in;
        if (we_i) begin
            case (sel)
                0: m_ctrl = data_i;
                1: m_out  = data_i[15:0];
                2: m_en   = data_i;
                4: m_div  = data_i[15:0];
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [15:0] gi);
        we_i = we; addr_i = a; data_i = d; gpio_in = gi;
        model_edge();
        @(posedge clk);
        #1;
        check("ctrl", gpio_io_ctrl, m_ctrl);
        check("out", {16'h0, gpio_out}, {16'h0, m_out});
        check("irq", {31'h0, irq_o}, {31'h0, m_irq});
        check("rd", data_o, model_read(addr_i));
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] v);
        we_i = 1'b0; addr_i = a;
        #1;
        v = data_o;
    endtask

    logic [31:0] v;
    logic [15:0] gi;
    int          bad;
    int          seen;

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; we_i = 1'b0; addr_i = '0; data_i = '0;
        gpio_in = '0; gi = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        for (int a = 0; a < 8; a++) begin
            peek(32'(a) << 2, v);
            check("rst_rd", v, 32'h0);
        end
        check("rst_ctrl", gpio_io_ctrl, 32'h0);
        check("rst_out", {16'h0, gpio_out}, 32'h0);
        check("rst_irq", {31'h0, irq_o}, 32'h0);

        // Output mode
        step(1, A_CTRL, 32'h5, 16'h0);
        step(1, A_DATA, 32'h3, 16'h0);
        check("out_ctrl", gpio_io_ctrl, 32'h5);
        check("out_data", {16'h0, gpio_out}, 32'h3);
        peek(A_DATA, v);
        check("out_rd", v, 32'h3);

        // Latency pad -> filt -> INT_STAT -> irq
        step(1, A_CTRL, 32'h2, 16'h0);
        step(1, A_DIV, 32'h0, 16'h0);
        step(1, A_EN, 32'h1, 16'h0);
        repeat (6) step(0, A_STAT, 32'h0, 16'h0);
        for (int k = 1; k <= 7; k++) begin
            step(0, A_STAT, 32'h0, 16'h1);
            peek(A_DATA, v);
            check($sformatf("lat_data%0d", k), {31'h0, v[0]},
                  (k >= 5) ? 32'h1 : 32'h0);
            peek(A_STAT, v);
            check($sformatf("lat_stat%0d", k), v,
                  (k >= 6) ? 32'h1 : 32'h0);
            check($sformatf("lat_irq%0d", k), {31'h0, irq_o},
                  (k >= 7) ? 32'h1 : 32'h0);
        end

        // W1C and irq drop
        step(1, A_STAT, 32'h1, 16'h1);
        peek(A_STAT, v);
        check("w1c_stat", v, 32'h0);
        check("w1c_irq_hold", {31'h0, irq_o}, 32'h1);
        step(0, A_STAT, 32'h0, 16'h1);
        check("w1c_irq_drop", {31'h0, irq_o}, 32'h0);

        // W1C collides with falling event: set wins
        step(1, A_EN, 32'h10000, 16'h1);
        repeat (5) step(0, A_STAT, 32'h0, 16'h0);
        step(1, A_STAT, 32'h1, 16'h0);
        peek(A_STAT, v);
        check("w1c_vs_set", v, 32'h1);
        step(1, A_STAT, 32'hFFFF, 16'h0);

        // Glitch filter with FILT_DIV=3
        step(1, A_DIV, 32'h3, 16'h0);
        step(1, A_EN, 32'h10001, 16'h0);
        repeat (10) step(0, A_STAT, 32'h0, 16'h0);
        bad = 0;
        for (int k = 0; k < 28; k++) begin
            step(0, A_STAT, 32'h0, (k < 8) ? 16'h1 : 16'h0);
            peek(A_DATA, v);
            if (v[0]) bad++;
            peek(A_STAT, v);
            if (v != 0) bad++;
        end
        check("glitch_rej", 32'(bad), 32'h0);
        seen = 0;
        for (int k = 0; k < 32; k++) begin
            step(0, A_STAT, 32'h0, (k < 12) ? 16'h1 : 16'h0);
            peek(A_DATA, v);
            if (v[0]) seen = 1;
        end
        check("pulse_pass", 32'(seen), 32'h1);
        step(1, A_STAT, 32'hFFFF, 16'h0);

        // Pin 1 in mode 11 ignores its pad
        step(1, A_CTRL, 32'hE, 16'h0);
        step(1, A_DATA, 32'h2, 16'h0);
        step(1, A_EN, 32'h30003, 16'h0);
        step(1, A_STAT, 32'hFFFF, 16'h0);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            step(0, A_DATA, 32'h0, ((k / 5) % 2 == 1) ? 16'h2 : 16'h0);
            peek(A_DATA, v);
            if (v[1] !== 1'b1) bad++;
            peek(A_STAT, v);
            if (v[1] !== 1'b0) bad++;
        end
        check("mode11", 32'(bad), 32'h0);

        // Random traffic with a mid-run asynchronous reset
        gi = 16'h0;
        for (int k = 0; k < 400; k++) begin
            logic        we;
            logic [31:0] a, d;
            we = ($urandom_range(0, 3) == 0);
            a  = $urandom();
            d  = $urandom();
            if (a[4:2] == 3'd4) d = 32'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0)
                gi = gi ^ (16'h1 << $urandom_range(0, 15));
            step(we, a, d, gi);
            if (k == 200) begin
                rst = 1'b1;
                #1;
                model_reset();
                check("arst_ctrl", gpio_io_ctrl, 32'h0);
                check("arst_out", {16'h0, gpio_out}, 32'h0);
                check("arst_irq", {31'h0, irq_o}, 32'h0);
                check("arst_rd", data_o, 32'h0);
                #2 rst = 1'b0;
            end
        end

        for (int a = 0; a < 8; a++) begin
            peek(32'(a) << 2, v);
            check("final_rd", v, model_read(32'(a) << 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
